register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have port clk, input, 1 bit, single rising-edge clock.
REQ-002 SHALL have port reset, input, 1 bit, synchronous active-high reset, sampled on clk rising edge.
REQ-003 SHALL have port GRF_write_enable, input, 1 bit, write-back commit strobe.
REQ-004 SHALL have port GRF_write_addr, input, 5 bits, destination register.
REQ-005 SHALL have port GRF_write_data, input, 32 bits, value to commit.
REQ-006 SHALL have ports read_addr1 and read_addr2, input, 5 bits each, decode-stage source registers.
REQ-007 SHALL have ports read_data1 and read_data2, output, 32 bits each, source operand values.
REQ-008 SHALL have port issue_enable, input, 1 bit, a register-writing instruction leaves decode this cycle.
REQ-009 SHALL have port issue_addr, input, 5 bits, that instruction's destination register.
REQ-010 SHALL have ports busy1 and busy2, output, 1 bit each, high when read_addr1 or read_addr2 has a pending write.
REQ-011 SHALL have port scoreboard_error, output, 1 bit, sticky overflow/underflow flag.

Function
REQ-012 SHALL hold 32 x 32-bit registers; register 0 SHALL always read 0, and writes to it SHALL be discarded.
REQ-013 SHALL commit GRF_write_data to GRF_write_addr on the clk edge when GRF_write_enable=1 and GRF_write_addr!=0.
REQ-014 SHALL drive read_data1/2 combinationally from the array (0-cycle read latency).
REQ-015 SHALL keep a 2-bit in-flight counter per register 1..31; the register 0 counter SHALL be constant 0.
REQ-016 SHALL, per edge and per register r, increment the counter on an issue to r only, decrement it on a write to r only, and leave it unchanged when both target r in the same cycle.
REQ-017 SHALL ignore issue_enable and GRF_write_enable for the scoreboard when the address is 0.
REQ-018 SHALL saturate the counter at 3: an issue at 3 leaves it at 3 and sets scoreboard_error on the next edge.
REQ-019 SHALL treat a write to a register whose counter is 0 as underflow: the counter stays 0 and scoreboard_error is set; the data write still commits.
REQ-020 SHALL drive busyN = (counter[read_addrN] != 0), combinationally from registered state, with no same-cycle forwarding of issue or write.
REQ-021 SHALL hold scoreboard_error high once set, until reset.

Reset
REQ-022 SHALL, on a reset edge, clear all registers and counters and clear scoreboard_error; any write or issue in that same cycle SHALL be discarded.
REQ-023 SHALL present read_data1/2=0, busy1/2=0 and scoreboard_error=0 in the cycle after reset.

Configuration
REQ-024 SHALL support macro GRF_BYPASS_EN; when defined, read_dataN SHALL return GRF_write_data whenever GRF_write_enable=1 and GRF_write_addr==read_addrN!=0 in the same cycle, and busyN SHALL also be low if that write retires the last pending write (counter==1) to read_addrN.
REQ-025 SHALL, without GRF_BYPASS_EN, show the new value on read_dataN only from the cycle after the commit edge, with busy cleared no earlier than that cycle.

Verification
REQ-026 SHALL cover: write reg 5=0x12345678, then read_addr1=5 -> read_data1=0x12345678 in the next cycle.
REQ-027 SHALL cover: write reg 0=0xFFFFFFFF -> read_data1=0 with read_addr1=0; scoreboard unchanged.
REQ-028 SHALL cover: issue to reg 8 at cycle 0 -> busy1=1 at cycle 1 (read_addr1=8); write to reg 8 at cycle 3 -> busy1=0 at cycle 4 (without bypass) or at cycle 3 (with bypass).
REQ-029 SHALL cover: same-cycle write to reg 9=0xA5A5A5A5 with read_addr2=9 -> read_data2=0xA5A5A5A5 in that cycle with GRF_BYPASS_EN, and the old value without it.
REQ-030 SHALL cover: four issues to reg 3 with no writes -> counter 3 and scoreboard_error=1 after the 4th edge; separately, a write to an idle reg 4 -> scoreboard_error=1.
REQ-031 SHALL cover: simultaneous issue and write to reg 7 with counter 1 -> counter stays 1; then reset asserted mid-sequence -> all outputs 0 in the next cycle.

Source files
------------

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
//  Module      : register_file
//  Description : 32 x 32-bit general register file with a per-register
//                in-flight write scoreboard (2-bit saturating counters),
//                combinational read ports, busy flags and a sticky
//                overflow/underflow error flag.
//                Optional macro GRF_BYPASS_EN forwards a same-cycle
//                write-back to the read ports and to the busy flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_file (
    input  logic        clk,
    input  logic        reset,
    input  logic        GRF_write_enable,
    input  logic [4:0]  GRF_write_addr,
    input  logic [31:0] GRF_write_data,
    input  logic [4:0]  read_addr1,
    input  logic [4:0]  read_addr2,
    output logic [31:0] read_data1,
    output logic [31:0] read_data2,
    input  logic        issue_enable,
    input  logic [4:0]  issue_addr,
    output logic        busy1,
    output logic        busy2,
    output logic        scoreboard_error
);

    localparam int unsigned c_NUM_REGS  = 32;
    localparam logic [1:0]  c_CNT_MAX   = 2'd3;
    localparam logic [1:0]  c_CNT_ZERO  = 2'd0;
    localparam logic [1:0]  c_CNT_ONE   = 2'd1;

    // Storage for registers 1..31; register 0 is hard-wired to zero.
    logic [31:0] r_regs [1:c_NUM_REGS-1];

    // In-flight counters, indexed by register; entry 0 is tied to zero.
    logic [1:0]  w_cnt  [0:c_NUM_REGS-1];

    // Per-register scoreboard events for the current cycle.
    logic [c_NUM_REGS-1:1] w_ovf;
    logic [c_NUM_REGS-1:1] w_unf;

    logic        r_err;

    // Qualified strobes: address 0 never touches state.
    logic        w_wr_valid;
    logic        w_iss_valid;

    assign w_wr_valid  = GRF_write_enable && (GRF_write_addr != 5'd0);
    assign w_iss_valid = issue_enable     && (issue_addr     != 5'd0);

    assign w_cnt[0] = c_CNT_ZERO;

    // ------------------------------------------------------------------
    // Data array
    // ------------------------------------------------------------------

    // Commit write-back data; reset clears every register and drops any
    // write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < c_NUM_REGS; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (w_wr_valid) begin
            r_regs[GRF_write_addr] <= GRF_write_data;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard counters, one per architectural register 1..31
    // ------------------------------------------------------------------
    generate
        for (genvar g = 1; g < c_NUM_REGS; g++) begin : g_cnt
            logic       w_inc;
            logic       w_dec;
            logic [1:0] r_cnt;
            logic [1:0] w_cnt_nxt;

            assign w_inc = w_iss_valid && (issue_addr     == 5'(g));
            assign w_dec = w_wr_valid  && (GRF_write_addr == 5'(g));

            // An issue and a retire to the same register cancel out; only
            // one-sided events move the counter, saturating at both ends.
            always_comb begin
                w_cnt_nxt = r_cnt;
                w_ovf[g]  = 1'b0;
                w_unf[g]  = 1'b0;
                if (w_inc && !w_dec) begin
                    if (r_cnt == c_CNT_MAX) begin
                        w_ovf[g] = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 2'd1;
                    end
                end else if (w_dec && !w_inc) begin
                    if (r_cnt == c_CNT_ZERO) begin
                        w_unf[g] = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - 2'd1;
                    end
                end
            end

            // Counter register, cleared by reset.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt <= c_CNT_ZERO;
                end else begin
                    r_cnt <= w_cnt_nxt;
                end
            end

            assign w_cnt[g] = r_cnt;
        end
    endgenerate

    // Sticky error: any overflow or underflow latches until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if ((|w_ovf) || (|w_unf)) begin
            r_err <= 1'b1;
        end
    end

    assign scoreboard_error = r_err;

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    logic [31:0] w_arr1;
    logic [31:0] w_arr2;

    // Array lookup with register 0 forced to zero.
    always_comb begin
        w_arr1 = 32'd0;
        w_arr2 = 32'd0;
        if (read_addr1 != 5'd0) begin
            w_arr1 = r_regs[read_addr1];
        end
        if (read_addr2 != 5'd0) begin
            w_arr2 = r_regs[read_addr2];
        end
    end

    logic w_pend1;
    logic w_pend2;

    assign w_pend1 = (w_cnt[read_addr1] != c_CNT_ZERO);
    assign w_pend2 = (w_cnt[read_addr2] != c_CNT_ZERO);

`ifdef GRF_BYPASS_EN
    logic w_fwd1;
    logic w_fwd2;
    logic w_retire1;
    logic w_retire2;

    // A write-back hitting a read address is visible in the same cycle.
    assign w_fwd1 = w_wr_valid && (GRF_write_addr == read_addr1);
    assign w_fwd2 = w_wr_valid && (GRF_write_addr == read_addr2);

    // The write retires the final outstanding write only if no new issue
    // to that register arrives in the same cycle (that would keep it busy).
    assign w_retire1 = w_fwd1 && (w_cnt[read_addr1] == c_CNT_ONE) &&
                       !(w_iss_valid && (issue_addr == read_addr1));
    assign w_retire2 = w_fwd2 && (w_cnt[read_addr2] == c_CNT_ONE) &&
                       !(w_iss_valid && (issue_addr == read_addr2));

    // Forwarding mux for operand data and busy flags.
    always_comb begin
        read_data1 = w_arr1;
        read_data2 = w_arr2;
        busy1      = w_pend1 && !w_retire1;
        busy2      = w_pend2 && !w_retire2;
        if (w_fwd1) begin
            read_data1 = GRF_write_data;
        end
        if (w_fwd2) begin
            read_data2 = GRF_write_data;
        end
    end
`else
    // Without forwarding, outputs reflect registered state only.
    always_comb begin
        read_data1 = w_arr1;
        read_data2 = w_arr2;
        busy1      = w_pend1;
        busy2      = w_pend2;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_file
//  Description : Self-checking bench for register_file: directed scenarios
//                plus randomized traffic against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file;

`ifdef GRF_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        GRF_write_enable;
    logic [4:0]  GRF_write_addr;
    logic [31:0] GRF_write_data;
    logic [4:0]  read_addr1;
    logic [4:0]  read_addr2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic        issue_enable;
    logic [4:0]  issue_addr;
    logic        busy1;
    logic        busy2;
    logic        scoreboard_error;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] m_mem [0:31];
    int          m_cnt [0:31];
    bit          m_err;

    register_file dut (
        .clk              (clk),
        .reset            (reset),
        .GRF_write_enable (GRF_write_enable),
        .GRF_write_addr   (GRF_write_addr),
        .GRF_write_data   (GRF_write_data),
        .read_addr1       (read_addr1),
        .read_addr2       (read_addr2),
        .read_data1       (read_data1),
        .read_data2       (read_data2),
        .issue_enable     (issue_enable),
        .issue_addr       (issue_addr),
        .busy1            (busy1),
        .busy2            (busy2),
        .scoreboard_error (scoreboard_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: apply one clock edge using the inputs currently presented.
    task automatic model_update();
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i] = 32'd0;
                m_cnt[i] = 0;
            end
            m_err = 1'b0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                bit iss;
                bit wr;
                iss = issue_enable && (issue_addr == 5'(r));
                wr  = GRF_write_enable && (GRF_write_addr == 5'(r));
                if (wr) m_mem[r] = GRF_write_data;
                if (iss && !wr) begin
                    if (m_cnt[r] == 3) m_err = 1'b1;
                    else m_cnt[r] = m_cnt[r] + 1;
                end else if (wr && !iss) begin
                    if (m_cnt[r] == 0) m_err = 1'b1;
                    else m_cnt[r] = m_cnt[r] - 1;
                end
            end
        end
    endtask

    function automatic logic [31:0] exp_rd(logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (c_BYP && GRF_write_enable && GRF_write_addr == a) return GRF_write_data;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(logic [4:0] a);
        if (a == 5'd0 || m_cnt[a] == 0) return 1'b0;
        if (c_BYP && GRF_write_enable && GRF_write_addr == a && m_cnt[a] == 1 &&
            !(issue_enable && issue_addr == a)) return 1'b0;
        return 1'b1;
    endfunction

    // Present inputs just after the falling edge, then settle for sampling.
    task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic ie, input logic [4:0] ia,
                         input logic [4:0] r1, input logic [4:0] r2);
        reset            = rst;
        GRF_write_enable = we;
        GRF_write_addr   = wa;
        GRF_write_data   = wd;
        issue_enable     = ie;
        issue_addr       = ia;
        read_addr1       = r1;
        read_addr2       = r2;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
    endtask

    // Reset with a write and an issue in the same cycle: both must be dropped.
    task automatic test_reset();
        apply_reset();
        drive(1'b0, 1'b1, 5'd6, 32'hDEADBEEF, 1'b1, 5'd6, 5'd6, 5'd6);
        tick();
        drive(1'b1, 1'b1, 5'd6, 32'hCAFEF00D, 1'b1, 5'd6, 5'd6, 5'd6);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd6, 5'd6);
        checks++;
        if (read_data1 !== 32'd0 || read_data2 !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: got %h/%h want 0/0", read_data1, read_data2);
        end
        checks++;
        if (busy1 !== 1'b0 || busy2 !== 1'b0 || scoreboard_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got busy %b%b err %b want 00 0", busy1, busy2, scoreboard_error);
        end
    endtask

    task automatic test_write_read();
        apply_reset();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd0, 5'd0);
        tick();
        drive(1'b0, 1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd0);
        checks++;
        if (read_data1 !== 32'h12345678) begin
            errors++;
            $display("FAIL write_read: got %h want 12345678", read_data1);
        end
        checks++;
        if (busy1 !== 1'b0 || scoreboard_error !== 1'b0) begin
            errors++;
            $display("FAIL write_read_sb: got busy %b err %b want 0 0", busy1, scoreboard_error);
        end
    endtask

    task automatic test_reg0();
        apply_reset();
        drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0);
        checks++;
        if (read_data1 !== 32'd0) begin
            errors++;
            $display("FAIL reg0_same: got %h want 0", read_data1);
        end
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++;
        if (read_data1 !== 32'd0 || busy1 !== 1'b0 || scoreboard_error !== 1'b0) begin
            errors++;
            $display("FAIL reg0: got %h busy %b err %b want 0 0 0", read_data1, busy1, scoreboard_error);
        end
    endtask

    task automatic test_busy();
        apply_reset();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 5'd8, 5'd0);   // cycle 0
        checks++;
        if (busy1 !== 1'b0) begin
            errors++;
            $display("FAIL busy_c0: got %b want 0", busy1);
        end
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd8, 5'd0);   // cycle 1
        checks++;
        if (busy1 !== 1'b1) begin
            errors++;
            $display("FAIL busy_c1: got %b want 1", busy1);
        end
        tick();
        tick();                                                   // cycle 3
        drive(1'b0, 1'b1, 5'd8, 32'h00000088, 1'b0, 5'd0, 5'd8, 5'd0);
        checks++;
        if (busy1 !== !c_BYP) begin
            errors++;
            $display("FAIL busy_c3: got %b want %b", busy1, !c_BYP);
        end
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd8, 5'd0);   // cycle 4
        checks++;
        if (busy1 !== 1'b0 || read_data1 !== 32'h00000088) begin
            errors++;
            $display("FAIL busy_c4: got busy %b data %h want 0 00000088", busy1, read_data1);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] want;
        apply_reset();
        drive(1'b0, 1'b1, 5'd9, 32'h11111111, 1'b1, 5'd9, 5'd0, 5'd0);
        tick();
        drive(1'b0, 1'b1, 5'd9, 32'hA5A5A5A5, 1'b1, 5'd9, 5'd0, 5'd9);
        want = c_BYP ? 32'hA5A5A5A5 : 32'h11111111;
        checks++;
        if (read_data2 !== want) begin
            errors++;
            $display("FAIL bypass_same: got %h want %h", read_data2, want);
        end
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd9);
        checks++;
        if (read_data2 !== 32'hA5A5A5A5 || scoreboard_error !== 1'b0) begin
            errors++;
            $display("FAIL bypass_next: got %h err %b want a5a5a5a5 0", read_data2, scoreboard_error);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd0);
            checks++;
            if (scoreboard_error !== 1'b0) begin
                errors++;
                $display("FAIL ovf_pre%0d: got %b want 0", i, scoreboard_error);
            end
            tick();
        end
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd0);
        checks++;
        if (scoreboard_error !== 1'b1 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL ovf: got err %b busy %b want 1 1", scoreboard_error, busy1);
        end
        // Three writes drain the saturated counter to zero; flag stays set.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 5'd3, 32'(i), 1'b0, 5'd0, 5'd3, 5'd0);
            tick();
        end
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd0);
        checks++;
        if (busy1 !== 1'b0 || scoreboard_error !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drain: got busy %b err %b want 0 1", busy1, scoreboard_error);
        end
        apply_reset();
        drive(1'b0, 1'b1, 5'd4, 32'h44444444, 1'b0, 5'd0, 5'd0, 5'd4);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd4);
        checks++;
        if (scoreboard_error !== 1'b1 || read_data2 !== 32'h44444444 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL unf: got err %b data %h busy %b want 1 44444444 0",
                     scoreboard_error, read_data2, busy2);
        end
    endtask

    task automatic test_simul_and_reset();
        apply_reset();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd7);
        tick();
        drive(1'b0, 1'b1, 5'd7, 32'h77777777, 1'b1, 5'd7, 5'd7, 5'd7);
        checks++;
        if (busy1 !== 1'b1) begin
            errors++;
            $display("FAIL simul_same: got %b want 1", busy1);
        end
        tick();
        drive(1'b0, 1'b1, 5'd7, 32'h70707070, 1'b0, 5'd0, 5'd7, 5'd7);
        checks++;
        if (busy2 !== !c_BYP || scoreboard_error !== 1'b0) begin
            errors++;
            $display("FAIL simul_cnt1: got busy %b err %b want %b 0", busy2, scoreboard_error, !c_BYP);
        end
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd7);
        checks++;
        if (busy1 !== 1'b0 || scoreboard_error !== 1'b0 || read_data1 !== 32'h70707070) begin
            errors++;
            $display("FAIL simul_drain: got busy %b err %b data %h want 0 0 70707070",
                     busy1, scoreboard_error, read_data1);
        end
        tick();
        drive(1'b0, 1'b1, 5'd12, 32'h12121212, 1'b1, 5'd7, 5'd7, 5'd12);
        tick();
        drive(1'b1, 1'b1, 5'd7, 32'hFFFF0000, 1'b1, 5'd7, 5'd7, 5'd12);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd12);
        checks++;
        if (read_data1 !== 32'd0 || read_data2 !== 32'd0 || busy1 !== 1'b0 ||
            busy2 !== 1'b0 || scoreboard_error !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got %h %h %b %b %b want all 0",
                     read_data1, read_data2, busy1, busy2, scoreboard_error);
        end
    endtask

    // Random traffic on a narrow address window so hits are frequent.
    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            checks++;
            if (read_data1 !== exp_rd(read_addr1) || read_data2 !== exp_rd(read_addr2)) begin
                errors++;
                $display("FAIL rand_data @%0d: got %h %h want %h %h", n, read_data1, read_data2,
                         exp_rd(read_addr1), exp_rd(read_addr2));
            end
            checks++;
            if (busy1 !== exp_busy(read_addr1) || busy2 !== exp_busy(read_addr2) ||
                scoreboard_error !== m_err) begin
                errors++;
                $display("FAIL rand_flags @%0d: got %b %b %b want %b %b %b", n, busy1, busy2,
                         scoreboard_error, exp_busy(read_addr1), exp_busy(read_addr2), m_err);
            end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_mem[i] = 32'd0;
            m_cnt[i] = 0;
        end
        m_err = 1'b0;
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        test_reset();
        test_write_read();
        test_reg0();
        test_busy();
        test_bypass();
        test_overflow();
        test_simul_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
